// File: rtl/board_generator_if.sv
// Connection bundle between board_generator and its neighbours: request/seed inputs,
// the INITIAL_BOARD write port, status pulses and the BEGIN_GAME handshake.
interface board_generator_if;
  logic        GEN_REQ;
  logic [15:0] SEED;
  logic [4:0]  final_SIZE;
  logic        CELL_WE;
  logic [4:0]  CELL_ROW;
  logic [4:0]  CELL_COL;
  logic [2:0]  CELL_COLOR;
  logic        GEN_BUSY;
  logic        GEN_DONE;
  logic        GEN_ERR;
  logic        BEGIN_GAME;
  logic        ACK_BEGIN_GAME;

  modport master (
    input  GEN_REQ, SEED, final_SIZE, ACK_BEGIN_GAME,
    output CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR,
           GEN_BUSY, GEN_DONE, GEN_ERR, BEGIN_GAME
  );

  modport slave (
    output GEN_REQ, SEED, final_SIZE, ACK_BEGIN_GAME,
    input  CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR,
           GEN_BUSY, GEN_DONE, GEN_ERR, BEGIN_GAME
  );
endinterface

// File: rtl/board_generator.sv
// Fills INITIAL_BOARD with LFSR colours one cell per cycle, then hands off via BEGIN_GAME.
// Optional BG_NO_TRIVIAL_CORNER_EN: cells (0,1) and (1,0) may not repeat the colour of (0,0).
//
// state     | meaning
// IDLE      | waiting for GEN_REQ; illegal size pulses GEN_ERR
// FILL      | LFSR steps each cycle; accepted candidates are written row-major
// HANDSHAKE | BEGIN_GAME raised and held until ACK_BEGIN_GAME
// RELEASE   | waiting for ACK_BEGIN_GAME to drop, then GEN_DONE
module board_generator #(
  parameter int          NUM_COLORS   = 6,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input logic              CLOCK,
  input logic              RESET,
  board_generator_if.master bus
);

  typedef enum logic [1:0] {IDLE, FILL, HANDSHAKE, RELEASE} state_t;

  localparam logic [3:0] NUM_COLORS_W = 4'(NUM_COLORS);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_step;
  logic [4:0]  size_q, size_d;
  logic [4:0]  row_q, row_d, col_q, col_d;
  logic        cell_we_q, cell_we_d;
  logic [4:0]  cell_row_q, cell_row_d, cell_col_q, cell_col_d;
  logic [2:0]  cell_color_q, cell_color_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, begin_q, begin_d;
  logic [2:0]  cand;
  logic [4:0]  last_idx;
  logic        size_legal, corner_hit, accept;
`ifdef BG_NO_TRIVIAL_CORNER_EN
  logic [2:0]  corner_q, corner_d;
`endif

  assign lfsr_step  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign cand       = lfsr_step[2:0];
  assign last_idx   = size_q - 5'd1;
  // Legal edges are 2,6,...,26: low bits 2'b10 and no larger than 26.
  assign size_legal = (bus.final_SIZE[1:0] == 2'b10) && (bus.final_SIZE <= 5'd26);

`ifdef BG_NO_TRIVIAL_CORNER_EN
  assign corner_hit = (((row_q == 5'd0) && (col_q == 5'd1)) ||
                       ((row_q == 5'd1) && (col_q == 5'd0))) && (cand == corner_q);
`else
  assign corner_hit = 1'b0;
`endif

  assign accept = ({1'b0, cand} < NUM_COLORS_W) && !corner_hit;

  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    size_d       = size_q;
    row_d        = row_q;
    col_d        = col_q;
    cell_we_d    = 1'b0;
    cell_row_d   = cell_row_q;
    cell_col_d   = cell_col_q;
    cell_color_d = cell_color_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    begin_d      = begin_q;
`ifdef BG_NO_TRIVIAL_CORNER_EN
    corner_d     = corner_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.GEN_REQ) begin
          size_d = bus.final_SIZE;
          if (size_legal) begin
            lfsr_d  = (bus.SEED == 16'd0) ? SEED_DEFAULT : bus.SEED;
            row_d   = 5'd0;
            col_d   = 5'd0;
            busy_d  = 1'b1;
            state_d = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        lfsr_d = lfsr_step;
        if (accept) begin
          cell_we_d    = 1'b1;
          cell_row_d   = row_q;
          cell_col_d   = col_q;
          cell_color_d = cand;
`ifdef BG_NO_TRIVIAL_CORNER_EN
          if ((row_q == 5'd0) && (col_q == 5'd0)) corner_d = cand;
`endif
          if (col_q == last_idx) begin
            col_d = 5'd0;
            if (row_q == last_idx) state_d = HANDSHAKE;
            else                   row_d   = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      HANDSHAKE: begin
        // First cycle here coincides with the last write; BEGIN_GAME follows one cycle later.
        if (!begin_q) begin
          begin_d = 1'b1;
        end else if (bus.ACK_BEGIN_GAME) begin
          begin_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.ACK_BEGIN_GAME) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      lfsr_q       <= SEED_DEFAULT;
      size_q       <= 5'd0;
      row_q        <= 5'd0;
      col_q        <= 5'd0;
      cell_we_q    <= 1'b0;
      cell_row_q   <= 5'd0;
      cell_col_q   <= 5'd0;
      cell_color_q <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      begin_q      <= 1'b0;
`ifdef BG_NO_TRIVIAL_CORNER_EN
      corner_q     <= 3'd0;
`endif
    end else begin
      lfsr_q       <= lfsr_d;
      size_q       <= size_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cell_we_q    <= cell_we_d;
      cell_row_q   <= cell_row_d;
      cell_col_q   <= cell_col_d;
      cell_color_q <= cell_color_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      begin_q      <= begin_d;
`ifdef BG_NO_TRIVIAL_CORNER_EN
      corner_q     <= corner_d;
`endif
    end
  end

  assign bus.CELL_WE    = cell_we_q;
  assign bus.CELL_ROW   = cell_row_q;
  assign bus.CELL_COL   = cell_col_q;
  assign bus.CELL_COLOR = cell_color_q;
  assign bus.GEN_BUSY   = busy_q;
  assign bus.GEN_DONE   = done_q;
  assign bus.GEN_ERR    = err_q;
  assign bus.BEGIN_GAME = begin_q;

endmodule

// File: tb/tb_board_generator.sv
// Self-checking bench for board_generator: a cell-by-cell colour model drives
// cycle-exact expectations for every write strobe, coordinate and colour.
module tb_board_generator;
  localparam int NUM_COLORS = 6;
`ifdef BG_NO_TRIVIAL_CORNER_EN
  localparam bit CORNER_EN = 1'b1;
`else
  localparam bit CORNER_EN = 1'b0;
`endif

  logic CLOCK;
  logic RESET;
  board_generator_if bif ();

  board_generator #(.NUM_COLORS(NUM_COLORS), .SEED_DEFAULT(16'hACE1)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bif)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  bit m_acc[$];
  int m_row[$];
  int m_col[$];
  int m_color[$];
  int cap_color[$];
  int cap_a[$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Per cell: keep drawing candidates until one is legal; each draw is one FILL cycle.
  task automatic build_model(input logic [15:0] seed, input int size);
    logic [15:0] s;
    int cand;
    int corner;
    bit got;
    m_acc.delete(); m_row.delete(); m_col.delete(); m_color.delete();
    s = (seed == 16'd0) ? 16'hACE1 : seed;
    corner = -1;
    for (int k = 0; k < size * size; k++) begin
      got = 1'b0;
      while (!got) begin
        s = lfsr_next(s);
        cand = int'(s[2:0]);
        if (cand < NUM_COLORS && !(CORNER_EN && (k == 1 || k == size) && cand == corner)) begin
          got = 1'b1;
          m_acc.push_back(1'b1);
          m_row.push_back(k / size);
          m_col.push_back(k % size);
          m_color.push_back(cand);
          if (k == 0) corner = cand;
        end else begin
          m_acc.push_back(1'b0);
        end
      end
    end
  endtask

  task automatic run_gen(input logic [15:0] seed, input int size, input int ack_delay,
                         input bit noise, input bit req_in_hs, output int nw);
    int n;
    build_model(seed, size);
    cap_color.delete();
    n = m_acc.size();
    nw = 0;
    bif.GEN_REQ = 1'b1;
    bif.SEED = seed;
    bif.final_SIZE = 5'(size);
    @(posedge CLOCK); #1;
    bif.GEN_REQ = 1'b0;
    checks++;
    if (bif.GEN_BUSY !== 1'b1 || bif.CELL_WE !== 1'b0) begin
      errors++;
      $display("FAIL start busy=%0b we=%0b exp busy=1 we=0", bif.GEN_BUSY, bif.CELL_WE);
    end
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        bif.final_SIZE = 5'($urandom_range(0, 31));
        bif.ACK_BEGIN_GAME = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        bif.GEN_REQ = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge CLOCK); #1;
      checks++;
      if (bif.CELL_WE !== m_acc[i] || bif.BEGIN_GAME !== 1'b0) begin
        errors++;
        $display("FAIL fill_we step=%0d we=%0b exp=%0b begin=%0b", i, bif.CELL_WE, m_acc[i], bif.BEGIN_GAME);
      end
      if (bif.CELL_WE === 1'b1 && nw < size * size) begin
        checks++;
        if (bif.CELL_ROW !== 5'(m_row[nw]) || bif.CELL_COL !== 5'(m_col[nw]) ||
            bif.CELL_COLOR !== 3'(m_color[nw])) begin
          errors++;
          $display("FAIL cell n=%0d got (%0d,%0d)=%0d exp (%0d,%0d)=%0d", nw, bif.CELL_ROW,
                   bif.CELL_COL, bif.CELL_COLOR, m_row[nw], m_col[nw], m_color[nw]);
        end
        cap_color.push_back(int'(bif.CELL_COLOR));
      end
      if (bif.CELL_WE === 1'b1) nw++;
    end
    bif.ACK_BEGIN_GAME = 1'b0;
    bif.GEN_REQ = 1'b0;
    checks++;
    if (nw != size * size) begin
      errors++;
      $display("FAIL write_count got=%0d exp=%0d", nw, size * size);
    end
    @(posedge CLOCK); #1;
    checks++;
    if (bif.BEGIN_GAME !== 1'b1 || bif.CELL_WE !== 1'b0) begin
      errors++;
      $display("FAIL begin_rise begin=%0b we=%0b exp begin=1 we=0", bif.BEGIN_GAME, bif.CELL_WE);
    end
    for (int k = 0; k < ack_delay; k++) begin
      if (req_in_hs) begin
        bif.GEN_REQ = 1'b1;
        bif.final_SIZE = 5'd7;
      end
      @(posedge CLOCK); #1;
      checks++;
      if (bif.BEGIN_GAME !== 1'b1 || bif.GEN_ERR !== 1'b0) begin
        errors++;
        $display("FAIL begin_hold k=%0d begin=%0b err=%0b exp begin=1 err=0", k, bif.BEGIN_GAME, bif.GEN_ERR);
      end
    end
    bif.GEN_REQ = 1'b0;
    bif.ACK_BEGIN_GAME = 1'b1;
    @(posedge CLOCK); #1;
    checks++;
    if (bif.BEGIN_GAME !== 1'b0 || bif.GEN_DONE !== 1'b0) begin
      errors++;
      $display("FAIL begin_drop begin=%0b done=%0b exp 0 0", bif.BEGIN_GAME, bif.GEN_DONE);
    end
    bif.ACK_BEGIN_GAME = 1'b0;
    @(posedge CLOCK); #1;
    checks++;
    if (bif.GEN_DONE !== 1'b1 || bif.GEN_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL done done=%0b busy=%0b exp done=1 busy=0", bif.GEN_DONE, bif.GEN_BUSY);
    end
    @(posedge CLOCK); #1;
    checks++;
    if (bif.GEN_DONE !== 1'b0 || bif.GEN_BUSY !== 1'b0 || bif.CELL_WE !== 1'b0 || bif.GEN_ERR !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%0b busy=%0b we=%0b err=%0b exp all 0",
               bif.GEN_DONE, bif.GEN_BUSY, bif.CELL_WE, bif.GEN_ERR);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bif.GEN_REQ = 1'b0; bif.SEED = 16'd0; bif.final_SIZE = 5'd0; bif.ACK_BEGIN_GAME = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++;
    if ({bif.CELL_WE, bif.CELL_ROW, bif.CELL_COL, bif.CELL_COLOR, bif.GEN_BUSY, bif.GEN_DONE,
         bif.GEN_ERR, bif.BEGIN_GAME} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs we=%0b row=%0d col=%0d color=%0d busy=%0b done=%0b err=%0b begin=%0b exp all 0",
               bif.CELL_WE, bif.CELL_ROW, bif.CELL_COL, bif.CELL_COLOR, bif.GEN_BUSY,
               bif.GEN_DONE, bif.GEN_ERR, bif.BEGIN_GAME);
    end
    RESET = 1'b0;
    @(posedge CLOCK); #1;
  endtask

  task automatic test_basic();
    int nw;
    run_gen(16'hACE1, 2, 1, 1'b0, 1'b0, nw);
    checks++;
    if (cap_color.size() != 4) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=4", cap_color.size());
    end
    foreach (cap_color[i]) begin
      checks++;
      if (cap_color[i] >= NUM_COLORS) begin
        errors++;
        $display("FAIL basic_range i=%0d got=%0d exp <%0d", i, cap_color[i], NUM_COLORS);
      end
    end
  endtask

  task automatic test_illegal();
    int sizes[4] = '{7, 0, 30, 27};
    foreach (sizes[j]) begin
      bif.GEN_REQ = 1'b1;
      bif.SEED = 16'h1234;
      bif.final_SIZE = 5'(sizes[j]);
      @(posedge CLOCK); #1;
      bif.GEN_REQ = 1'b0;
      checks++;
      if (bif.GEN_ERR !== 1'b1 || bif.GEN_BUSY !== 1'b0 || bif.CELL_WE !== 1'b0) begin
        errors++;
        $display("FAIL illegal_err size=%0d err=%0b busy=%0b we=%0b exp 1 0 0",
                 sizes[j], bif.GEN_ERR, bif.GEN_BUSY, bif.CELL_WE);
      end
      repeat (3) begin
        @(posedge CLOCK); #1;
        checks++;
        if (bif.GEN_ERR !== 1'b0 || bif.GEN_BUSY !== 1'b0 || bif.CELL_WE !== 1'b0) begin
          errors++;
          $display("FAIL illegal_after size=%0d err=%0b busy=%0b we=%0b exp 0 0 0",
                   sizes[j], bif.GEN_ERR, bif.GEN_BUSY, bif.CELL_WE);
        end
      end
    end
  endtask

  task automatic test_seed_zero();
    int nw;
    run_gen(16'h0000, 6, 2, 1'b0, 1'b0, nw);
    cap_a = cap_color;
    run_gen(16'hACE1, 6, 0, 1'b1, 1'b0, nw);
    checks++;
    if (cap_a != cap_color || cap_a.size() != 36) begin
      errors++;
      $display("FAIL seed_zero sizes %0d/%0d streams differ or not 36", cap_a.size(), cap_color.size());
    end
  endtask

  task automatic test_size26();
    int nw;
    logic [15:0] seed;
    seed = 16'($urandom_range(1, 65535));
    run_gen(seed, 26, 3, 1'b1, 1'b0, nw);
    cap_a = cap_color;
    run_gen(seed, 26, 1, 1'b0, 1'b0, nw);
    checks++;
    if (cap_a != cap_color || cap_a.size() != 676) begin
      errors++;
      $display("FAIL size26_repeat seed=%h sizes %0d/%0d exp identical 676", seed, cap_a.size(), cap_color.size());
    end
  endtask

  task automatic test_random();
    int sizes[7] = '{2, 6, 10, 14, 18, 22, 26};
    int nw;
    for (int r = 0; r < 6; r++) begin
      run_gen(16'($urandom), sizes[$urandom_range(0, 4)], $urandom_range(0, 4), 1'b1, 1'b0, nw);
    end
  endtask

  task automatic test_reset_mid_fill();
    int nw;
    bit hit;
    build_model(16'h5A5A, 10);
    bif.GEN_REQ = 1'b1; bif.SEED = 16'h5A5A; bif.final_SIZE = 5'd10;
    @(posedge CLOCK); #1;
    bif.GEN_REQ = 1'b0;
    nw = 0;
    hit = 1'b0;
    for (int c = 0; c < m_acc.size() && !hit; c++) begin
      @(posedge CLOCK); #1;
      if (bif.CELL_WE === 1'b1) nw++;
      if (nw == 10) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach writes=%0d exp 10", nw);
    end
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    checks++;
    if ({bif.CELL_WE, bif.CELL_ROW, bif.CELL_COL, bif.CELL_COLOR, bif.GEN_BUSY, bif.GEN_DONE,
         bif.GEN_ERR, bif.BEGIN_GAME} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs we=%0b row=%0d col=%0d busy=%0b done=%0b begin=%0b exp all 0",
               bif.CELL_WE, bif.CELL_ROW, bif.CELL_COL, bif.GEN_BUSY, bif.GEN_DONE, bif.BEGIN_GAME);
    end
    RESET = 1'b0;
    repeat (3) begin
      @(posedge CLOCK); #1;
      checks++;
      if (bif.CELL_WE !== 1'b0 || bif.GEN_DONE !== 1'b0 || bif.GEN_BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle we=%0b done=%0b busy=%0b exp 0", bif.CELL_WE, bif.GEN_DONE, bif.GEN_BUSY);
      end
    end
    run_gen(16'h5A5A, 2, 1, 1'b0, 1'b0, nw);
  endtask

  task automatic test_handshake_ignore();
    int nw;
    run_gen(16'h9C3B, 2, 3, 1'b0, 1'b1, nw);
  endtask

  task automatic test_corner();
    int nw;
    for (int r = 0; r < 200; r++) begin
      run_gen(16'($urandom), 2, 0, 1'b0, 1'b0, nw);
      checks++;
      if (cap_color.size() != 4 || cap_color[1] == cap_color[0] || cap_color[2] == cap_color[0]) begin
        errors++;
        $display("FAIL corner run=%0d n=%0d colors not distinct from corner", r, cap_color.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_seed_zero();
    test_size26();
    test_random();
    test_reset_mid_fill();
    test_handshake_ignore();
    if (CORNER_EN) test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
